// File: rtl/password_checker.sv
// rtl/password_checker.sv - code checker scanning a synchronous-read code memory with failure lockout
module password_checker #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enter,
    input  logic [WIDTH-1:0]                  senha,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [WIDTH-1:0]                  mem_data,
    output logic                              busy,
    output logic                              status,
    output logic                              fail,
    output logic                              locked,
    output logic [ADDR_W-1:0]                 match_idx,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int FCW = $clog2(MAX_FAIL + 1);
    localparam int TW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [FCW-1:0]    FAIL_MAX  = FCW'(MAX_FAIL);
    localparam logic [TW-1:0]     LOCK_LOAD = TW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_MATCH = 3'd2,
        S_FAIL  = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   addr_dly_q, addr_dly_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [WIDTH-1:0]    code_q, code_d;
    logic [ADDR_W-1:0]   match_idx_q, match_idx_d;
    logic [FCW-1:0]      fail_cnt_q, fail_cnt_d;
    logic [TW-1:0]       lock_timer_q, lock_timer_d;

    // mem_data lags mem_addr by one cycle, so the hit is judged against the delayed address
    logic                hit;
    logic [FCW-1:0]      fail_inc;
    logic                last_fail;

    assign hit       = cmp_valid_q && (mem_data == code_q);
    assign fail_inc  = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FCW'(1);
    assign last_fail = (fail_inc == FAIL_MAX);

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            addr_dly_q   <= '0;
            cmp_valid_q  <= 1'b0;
            code_q       <= '0;
            match_idx_q  <= '0;
            fail_cnt_q   <= '0;
            lock_timer_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_dly_q   <= addr_dly_d;
            cmp_valid_q  <= cmp_valid_d;
            code_q       <= code_d;
            match_idx_q  <= match_idx_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_timer_q <= lock_timer_d;
        end
    end

    // next state: a hit beats the end-of-table miss
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enter) state_d = S_SCAN;
            S_SCAN: begin
                if (hit)
                    state_d = S_MATCH;
                else if (cmp_valid_q && (addr_dly_q == LAST_ADDR))
                    state_d = S_FAIL;
            end
            S_MATCH: state_d = S_IDLE;
            S_FAIL:  state_d = last_fail ? S_LOCK : S_IDLE;
            S_LOCK:  if (lock_timer_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // datapath updates for code capture, address walk, failure counting and lockout timer
    always_comb begin
        addr_d       = addr_q;
        addr_dly_d   = addr_dly_q;
        cmp_valid_d  = cmp_valid_q;
        code_d       = code_q;
        match_idx_d  = match_idx_q;
        fail_cnt_d   = fail_cnt_q;
        lock_timer_d = lock_timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (enter) begin
                    code_d      = senha;
                    addr_d      = '0;
                    cmp_valid_d = 1'b0;
                end
            end
            S_SCAN: begin
                addr_d      = (addr_q == LAST_ADDR) ? addr_q : addr_q + ADDR_W'(1);
                addr_dly_d  = addr_q;
                cmp_valid_d = 1'b1;
                if (hit) match_idx_d = addr_dly_q;
            end
            S_MATCH: fail_cnt_d = '0;
            S_FAIL: begin
                fail_cnt_d = fail_inc;
                if (last_fail) lock_timer_d = LOCK_LOAD;
            end
            S_LOCK: begin
                if (lock_timer_q == '0)
                    fail_cnt_d = '0;
                else
                    lock_timer_d = lock_timer_q - TW'(1);
            end
            default: ;
        endcase
    end

    // status flags decoded from the state register alone
    always_comb begin
        busy   = (state_q == S_SCAN) || (state_q == S_MATCH) || (state_q == S_FAIL);
        status = (state_q == S_MATCH);
        fail   = (state_q == S_FAIL);
        locked = (state_q == S_LOCK);
    end

    assign mem_addr  = addr_q;
    assign match_idx = match_idx_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
